// File: rtl/ahbl_pkg.sv
// ahbl_pkg: shared AHB-Lite encodings and the arbiter port FSM state type.
//   HTRANS_* : transfer type encodings
//   HSIZE_*  : transfer size encodings
//   port_state_t : per-master port FSM states
package ahbl_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE  = 3'b000;
    localparam logic [2:0] HSIZE_HALF  = 3'b001;
    localparam logic [2:0] HSIZE_WORD  = 3'b010;
    localparam logic [2:0] HSIZE_DWORD = 3'b011;

    typedef enum logic [1:0] {
        PORT_IDLE = 2'b00,
        PORT_PEND = 2'b01,
        PORT_ADDR = 2'b10,
        PORT_DATA = 2'b11
    } port_state_t;

endpackage

// File: rtl/ahbl_arb_port.sv
// ahbl_arb_port: one master-side port of the two-master AHB-Lite arbiter.
// Captures the master's address phase into a one-entry buffer, tracks the
// transfer through pending / slave address phase / slave data phase, and
// generates the master-side HREADY.
// Ports:
//   HCLK, HRESETn      clock, async active-low reset
//   req                master request (HTRANS[1])
//   haddr/hsize/hwrite master address-phase signals
//   grant              scheduler grant (valid while pend=1)
//   s_hready           slave ready
//   hready             master-side ready
//   pend/in_addr/in_data  port state flags for the scheduler and muxes
//   cap_addr/cap_size/cap_write  captured address phase
module ahbl_arb_port
    import ahbl_pkg::*;
(
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        req,
    input  logic [31:0] haddr,
    input  logic [2:0]  hsize,
    input  logic        hwrite,
    input  logic        grant,
    input  logic        s_hready,
    output logic        hready,
    output logic        pend,
    output logic        in_addr,
    output logic        in_data,
    output logic [31:0] cap_addr,
    output logic [2:0]  cap_size,
    output logic        cap_write
);

    port_state_t state, state_nxt;
    logic        capture;

    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        case (state)
            PORT_IDLE: begin
                if (req) begin
                    state_nxt = PORT_PEND;
                    capture   = 1'b1;
                end
            end
            PORT_PEND: begin
                if (grant) state_nxt = PORT_ADDR;
            end
            PORT_ADDR: begin
                if (s_hready) state_nxt = PORT_DATA;
            end
            PORT_DATA: begin
                // Master HREADY follows S_HREADY here, so a request seen on
                // the completing edge is a legal back-to-back address phase.
                if (s_hready) begin
                    if (req) begin
                        state_nxt = PORT_PEND;
                        capture   = 1'b1;
                    end else begin
                        state_nxt = PORT_IDLE;
                    end
                end
            end
            default: state_nxt = PORT_IDLE;
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state     <= PORT_IDLE;
            cap_addr  <= '0;
            cap_size  <= '0;
            cap_write <= 1'b0;
        end else begin
            state <= state_nxt;
            if (capture) begin
                cap_addr  <= haddr;
                cap_size  <= hsize;
                cap_write <= hwrite;
            end
        end
    end

    assign pend    = (state == PORT_PEND);
    assign in_addr = (state == PORT_ADDR);
    assign in_data = (state == PORT_DATA);

    always_comb begin
        case (state)
            PORT_IDLE: hready = 1'b1;
            PORT_DATA: hready = s_hready;
            default:   hready = 1'b0;
        endcase
    end

endmodule

// File: rtl/ahbl_arbiter.sv
// ahbl_arbiter: two-master AHB-Lite arbiter sharing one slave path.
// Parameter RR: 1 = round-robin, 0 = fixed priority (M0 wins ties).
// Ports:
//   HCLK, HRESETn                 clock, async active-low reset
//   M0_*/M1_* HADDR/HTRANS/HSIZE/HWRITE/HWDATA  master inputs
//   M0_HREADY/M1_HREADY           per-master ready
//   M_HRDATA                      read data broadcast to both masters
//   S_HADDR/S_HTRANS/S_HSIZE/S_HWRITE/S_HWDATA  slave outputs
//   S_HREADY/S_HRDATA             slave inputs
module ahbl_arbiter
    import ahbl_pkg::*;
#(
    parameter logic RR = 1'b1
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic [31:0] M0_HADDR,
    input  logic [1:0]  M0_HTRANS,
    input  logic [2:0]  M0_HSIZE,
    input  logic        M0_HWRITE,
    input  logic [31:0] M0_HWDATA,
    output logic        M0_HREADY,
    input  logic [31:0] M1_HADDR,
    input  logic [1:0]  M1_HTRANS,
    input  logic [2:0]  M1_HSIZE,
    input  logic        M1_HWRITE,
    input  logic [31:0] M1_HWDATA,
    output logic        M1_HREADY,
    output logic [31:0] M_HRDATA,
    output logic [31:0] S_HADDR,
    output logic [1:0]  S_HTRANS,
    output logic [2:0]  S_HSIZE,
    output logic        S_HWRITE,
    output logic [31:0] S_HWDATA,
    input  logic        S_HREADY,
    input  logic [31:0] S_HRDATA
);

    logic        pend0, pend1, addr0, addr1, data0, data1;
    logic        gnt0, gnt1, slot_free, last_grant;
    logic [31:0] cap_addr0, cap_addr1;
    logic [2:0]  cap_size0, cap_size1;
    logic        cap_write0, cap_write1;
    logic        unused_htrans0;

    // SEQ is treated as NONSEQ and BUSY as IDLE, so only HTRANS[1] matters.
    assign unused_htrans0 = M0_HTRANS[0] ^ M1_HTRANS[0];

    ahbl_arb_port u_port0 (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .req       (M0_HTRANS[1]),
        .haddr     (M0_HADDR),
        .hsize     (M0_HSIZE),
        .hwrite    (M0_HWRITE),
        .grant     (gnt0),
        .s_hready  (S_HREADY),
        .hready    (M0_HREADY),
        .pend      (pend0),
        .in_addr   (addr0),
        .in_data   (data0),
        .cap_addr  (cap_addr0),
        .cap_size  (cap_size0),
        .cap_write (cap_write0)
    );

    ahbl_arb_port u_port1 (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .req       (M1_HTRANS[1]),
        .haddr     (M1_HADDR),
        .hsize     (M1_HSIZE),
        .hwrite    (M1_HWRITE),
        .grant     (gnt1),
        .s_hready  (S_HREADY),
        .hready    (M1_HREADY),
        .pend      (pend1),
        .in_addr   (addr1),
        .in_data   (data1),
        .cap_addr  (cap_addr1),
        .cap_size  (cap_size1),
        .cap_write (cap_write1)
    );

    // The address slot frees up on the edge that accepts the current
    // address phase, letting the next port overlap the data phase.
    assign slot_free = !(addr0 || addr1) || S_HREADY;

    // last_grant: 0 = M0 granted most recently, 1 = M1.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (slot_free) begin
            if (pend0 && pend1) begin
                if (RR && !last_grant) gnt1 = 1'b1;
                else                   gnt0 = 1'b1;
            end else begin
                gnt0 = pend0;
                gnt1 = pend1;
            end
        end
    end

    // Slave address signals are loaded at grant time; the capture buffer
    // cannot change while its port is in ADDR, so this also holds the last
    // issued values once the bus goes idle.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            last_grant <= 1'b1;
            S_HADDR    <= '0;
            S_HSIZE    <= '0;
            S_HWRITE   <= 1'b0;
        end else if (gnt0) begin
            last_grant <= 1'b0;
            S_HADDR    <= cap_addr0;
            S_HSIZE    <= cap_size0;
            S_HWRITE   <= cap_write0;
        end else if (gnt1) begin
            last_grant <= 1'b1;
            S_HADDR    <= cap_addr1;
            S_HSIZE    <= cap_size1;
            S_HWRITE   <= cap_write1;
        end
    end

    assign S_HTRANS = (addr0 || addr1) ? HTRANS_NONSEQ : HTRANS_IDLE;

    always_comb begin
        if (data0)      S_HWDATA = M0_HWDATA;
        else if (data1) S_HWDATA = M1_HWDATA;
        else            S_HWDATA = '0;
    end

    assign M_HRDATA = S_HRDATA;

endmodule

// File: tb/tb_ahbl_arbiter.sv
// tb_ahbl_arbiter: directed bench for ahbl_arbiter. Two instances share all
// inputs: dut_rr (round-robin) and dut_fp (fixed priority).
module tb_ahbl_arbiter;
    import ahbl_pkg::*;

    logic        HCLK, HRESETn;
    logic [31:0] M0_HADDR, M1_HADDR, M0_HWDATA, M1_HWDATA, S_HRDATA;
    logic [1:0]  M0_HTRANS, M1_HTRANS;
    logic [2:0]  M0_HSIZE, M1_HSIZE;
    logic        M0_HWRITE, M1_HWRITE, S_HREADY;

    logic        rr_M0_HREADY, rr_M1_HREADY, rr_S_HWRITE;
    logic [31:0] rr_M_HRDATA, rr_S_HADDR, rr_S_HWDATA;
    logic [1:0]  rr_S_HTRANS;
    logic [2:0]  rr_S_HSIZE;
    logic        fp_M0_HREADY, fp_M1_HREADY, fp_S_HWRITE;
    logic [31:0] fp_M_HRDATA, fp_S_HADDR, fp_S_HWDATA;
    logic [1:0]  fp_S_HTRANS;
    logic [2:0]  fp_S_HSIZE;

    int checks   = 0;
    int failures = 0;

    ahbl_arbiter #(.RR(1'b1)) dut_rr (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .M0_HADDR(M0_HADDR), .M0_HTRANS(M0_HTRANS), .M0_HSIZE(M0_HSIZE),
        .M0_HWRITE(M0_HWRITE), .M0_HWDATA(M0_HWDATA), .M0_HREADY(rr_M0_HREADY),
        .M1_HADDR(M1_HADDR), .M1_HTRANS(M1_HTRANS), .M1_HSIZE(M1_HSIZE),
        .M1_HWRITE(M1_HWRITE), .M1_HWDATA(M1_HWDATA), .M1_HREADY(rr_M1_HREADY),
        .M_HRDATA(rr_M_HRDATA), .S_HADDR(rr_S_HADDR), .S_HTRANS(rr_S_HTRANS),
        .S_HSIZE(rr_S_HSIZE), .S_HWRITE(rr_S_HWRITE), .S_HWDATA(rr_S_HWDATA),
        .S_HREADY(S_HREADY), .S_HRDATA(S_HRDATA)
    );

    ahbl_arbiter #(.RR(1'b0)) dut_fp (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .M0_HADDR(M0_HADDR), .M0_HTRANS(M0_HTRANS), .M0_HSIZE(M0_HSIZE),
        .M0_HWRITE(M0_HWRITE), .M0_HWDATA(M0_HWDATA), .M0_HREADY(fp_M0_HREADY),
        .M1_HADDR(M1_HADDR), .M1_HTRANS(M1_HTRANS), .M1_HSIZE(M1_HSIZE),
        .M1_HWRITE(M1_HWRITE), .M1_HWDATA(M1_HWDATA), .M1_HREADY(fp_M1_HREADY),
        .M_HRDATA(fp_M_HRDATA), .S_HADDR(fp_S_HADDR), .S_HTRANS(fp_S_HTRANS),
        .S_HSIZE(fp_S_HSIZE), .S_HWRITE(fp_S_HWRITE), .S_HWDATA(fp_S_HWDATA),
        .S_HREADY(S_HREADY), .S_HRDATA(S_HRDATA)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; inputs are then driven, and checks
    // follow a further #1.
    task automatic step();
        @(posedge HCLK);
        #1;
    endtask

    // Same-edge requests: M0 reads 0x41000000, M1 writes 0x20000000.
    task automatic tie(input string tag, input logic rr_m1_first);
        M0_HADDR = 32'h4100_0000; M0_HWRITE = 1'b0; M0_HSIZE = HSIZE_WORD;
        M0_HTRANS = HTRANS_NONSEQ; M0_HWDATA = 32'h0;
        M1_HADDR = 32'h2000_0000; M1_HWRITE = 1'b1; M1_HSIZE = HSIZE_WORD;
        M1_HTRANS = HTRANS_NONSEQ; M1_HWDATA = 32'h5555_AAAA;
        step();
        M0_HTRANS = HTRANS_IDLE; M1_HTRANS = HTRANS_IDLE;
        #1;
        chk({tag, "_pend_m0_hready"}, rr_M0_HREADY, 1'b0);
        chk({tag, "_pend_m1_hready"}, rr_M1_HREADY, 1'b0);
        step(); #1;
        chk({tag, "_rr_first_addr"}, rr_S_HADDR, rr_m1_first ? 32'h2000_0000 : 32'h4100_0000);
        chk({tag, "_fp_first_addr"}, fp_S_HADDR, 32'h4100_0000);
        chk({tag, "_rr_first_htrans"}, rr_S_HTRANS, HTRANS_NONSEQ);
        step(); #1;
        chk({tag, "_rr_second_addr"}, rr_S_HADDR, rr_m1_first ? 32'h4100_0000 : 32'h2000_0000);
        chk({tag, "_fp_second_addr"}, fp_S_HADDR, 32'h2000_0000);
        chk({tag, "_rr_first_wdata"}, rr_S_HWDATA, rr_m1_first ? 32'h5555_AAAA : 32'h0);
        step(); #1;
        chk({tag, "_rr_second_wdata"}, rr_S_HWDATA, rr_m1_first ? 32'h0 : 32'h5555_AAAA);
        chk({tag, "_rr_tail_htrans"}, rr_S_HTRANS, HTRANS_IDLE);
        step();
    endtask

    initial begin
        HRESETn = 1'b0; S_HREADY = 1'b1; S_HRDATA = 32'h0;
        M0_HADDR = 32'h0; M0_HTRANS = HTRANS_IDLE; M0_HSIZE = HSIZE_BYTE; M0_HWRITE = 1'b0; M0_HWDATA = 32'h0;
        M1_HADDR = 32'h0; M1_HTRANS = HTRANS_IDLE; M1_HSIZE = HSIZE_BYTE; M1_HWRITE = 1'b0; M1_HWDATA = 32'h0;
        step(); step();
        chk("rst_m0_hready", rr_M0_HREADY, 1'b1);
        chk("rst_m1_hready", rr_M1_HREADY, 1'b1);
        chk("rst_htrans", rr_S_HTRANS, HTRANS_IDLE);
        chk("rst_haddr", rr_S_HADDR, 32'h0);
        chk("rst_hwdata", rr_S_HWDATA, 32'h0);
        chk("rst_fp_htrans", fp_S_HTRANS, HTRANS_IDLE);
        HRESETn = 1'b1;
        #1;

        // Uncontended M0 write, zero-wait slave.
        M0_HADDR = 32'h4100_0000; M0_HTRANS = HTRANS_NONSEQ; M0_HWRITE = 1'b1; M0_HSIZE = HSIZE_WORD;
        #1;
        chk("t1_idle_m0_hready", rr_M0_HREADY, 1'b1);
        step();
        M0_HTRANS = HTRANS_IDLE; M0_HWDATA = 32'h1234_5678;
        #1;
        chk("t1_e0_m0_hready", rr_M0_HREADY, 1'b0);
        chk("t1_e0_htrans", rr_S_HTRANS, HTRANS_IDLE);
        step(); #1;
        chk("t1_addr_htrans", rr_S_HTRANS, HTRANS_NONSEQ);
        chk("t1_addr_haddr", rr_S_HADDR, 32'h4100_0000);
        chk("t1_addr_hsize", rr_S_HSIZE, HSIZE_WORD);
        chk("t1_addr_hwrite", rr_S_HWRITE, 1'b1);
        chk("t1_addr_m0_hready", rr_M0_HREADY, 1'b0);
        step(); #1;
        chk("t1_data_hwdata", rr_S_HWDATA, 32'h1234_5678);
        chk("t1_data_m0_hready", rr_M0_HREADY, 1'b1);
        chk("t1_data_htrans", rr_S_HTRANS, HTRANS_IDLE);
        step(); #1;
        chk("t1_done_m0_hready", rr_M0_HREADY, 1'b1);
        chk("t1_done_hwdata", rr_S_HWDATA, 32'h0);
        chk("t1_done_haddr_held", rr_S_HADDR, 32'h4100_0000);

        // Ties from reset: round-robin alternates, fixed priority keeps M0.
        HRESETn = 1'b0; #1; step(); HRESETn = 1'b1;
        tie("tie1", 1'b0);
        // A lone M0 transfer leaves M0 as the most recent grant.
        M0_HADDR = 32'h4100_0008; M0_HWRITE = 1'b0; M0_HTRANS = HTRANS_NONSEQ;
        step();
        M0_HTRANS = HTRANS_IDLE;
        step(); #1;
        chk("solo_m0_haddr", rr_S_HADDR, 32'h4100_0008);
        step(); step();
        tie("tie2", 1'b1);
        tie("tie3", 1'b1);

        // M1 read with a stalled address phase and 3 data wait states.
        M1_HADDR = 32'h3000_0000; M1_HWRITE = 1'b0; M1_HSIZE = HSIZE_WORD; M1_HTRANS = HTRANS_NONSEQ;
        step();
        M1_HTRANS = HTRANS_IDLE;
        M0_HADDR = 32'h4100_0004; M0_HWRITE = 1'b1; M0_HSIZE = HSIZE_WORD; M0_HTRANS = HTRANS_NONSEQ;
        #1;
        chk("t4_e0_m1_hready", rr_M1_HREADY, 1'b0);
        step();
        M0_HTRANS = HTRANS_IDLE; M0_HWDATA = 32'h0BAD_BEEF; S_HREADY = 1'b0;
        #1;
        chk("t4_m1_addr", rr_S_HADDR, 32'h3000_0000);
        chk("t4_m0_pend_hready", rr_M0_HREADY, 1'b0);
        step();
        S_HREADY = 1'b1;
        #1;
        chk("t4_stall_addr_held", rr_S_HADDR, 32'h3000_0000);
        chk("t4_stall_htrans", rr_S_HTRANS, HTRANS_NONSEQ);
        step();
        S_HREADY = 1'b0;
        #1;
        chk("t4_m0_addr_after_accept", rr_S_HADDR, 32'h4100_0004);
        chk("t4_m0_hwrite", rr_S_HWRITE, 1'b1);
        chk("t4_wait1_m1_hready", rr_M1_HREADY, 1'b0);
        step(); #1;
        chk("t4_wait2_m1_hready", rr_M1_HREADY, 1'b0);
        chk("t4_wait2_htrans", rr_S_HTRANS, HTRANS_NONSEQ);
        step(); #1;
        chk("t4_wait3_m1_hready", rr_M1_HREADY, 1'b0);
        step();
        S_HREADY = 1'b1; S_HRDATA = 32'hCAFE_F00D;
        #1;
        chk("t4_ready_m1_hready", rr_M1_HREADY, 1'b1);
        chk("t4_ready_hrdata", rr_M_HRDATA, 32'hCAFE_F00D);
        chk("t4_fp_ready_m1_hready", fp_M1_HREADY, 1'b1);
        step(); #1;
        chk("t4_m0_data_hwdata", rr_S_HWDATA, 32'h0BAD_BEEF);
        chk("t4_m0_data_hready", rr_M0_HREADY, 1'b1);
        chk("t4_m1_done_hready", rr_M1_HREADY, 1'b1);
        step(); step();

        // M0 back-to-back, M1 continuous: issue pattern M0, M1, idle repeats.
        M0_HADDR = 32'h4100_0010; M0_HWRITE = 1'b1; M0_HWDATA = 32'hA0A0_A0A0; M0_HTRANS = HTRANS_NONSEQ;
        step();
        M1_HADDR = 32'h2000_0010; M1_HWRITE = 1'b1; M1_HWDATA = 32'hB1B1_B1B1; M1_HTRANS = HTRANS_NONSEQ;
        for (int k = 0; k < 8; k++) begin
            step(); #1;
            case (k % 3)
                0: begin
                    chk("alt_htrans", rr_S_HTRANS, HTRANS_NONSEQ);
                    chk("alt_haddr_m0", rr_S_HADDR, 32'h4100_0010);
                    chk("alt_hwdata_none", rr_S_HWDATA, 32'h0);
                    chk("alt_m0_hready_addr", rr_M0_HREADY, 1'b0);
                end
                1: begin
                    chk("alt_htrans", rr_S_HTRANS, HTRANS_NONSEQ);
                    chk("alt_haddr_m1", rr_S_HADDR, 32'h2000_0010);
                    chk("alt_hwdata_m0", rr_S_HWDATA, 32'hA0A0_A0A0);
                    chk("alt_m0_hready_data", rr_M0_HREADY, 1'b1);
                end
                default: begin
                    chk("alt_htrans_gap", rr_S_HTRANS, HTRANS_IDLE);
                    chk("alt_haddr_held", rr_S_HADDR, 32'h2000_0010);
                    chk("alt_hwdata_m1", rr_S_HWDATA, 32'hB1B1_B1B1);
                    chk("alt_m0_hready_pend", rr_M0_HREADY, 1'b0);
                end
            endcase
        end
        M0_HTRANS = HTRANS_IDLE; M1_HTRANS = HTRANS_IDLE;
        step(); step(); step();

        // Reset during M1's slave data phase.
        M1_HADDR = 32'h3000_0020; M1_HWRITE = 1'b1; M1_HWDATA = 32'h7777_8888; M1_HTRANS = HTRANS_NONSEQ;
        step();
        M1_HTRANS = HTRANS_IDLE;
        step(); step(); #1;
        chk("t6_pre_hwdata", rr_S_HWDATA, 32'h7777_8888);
        S_HREADY = 1'b0; HRESETn = 1'b0;
        #1;
        chk("t6_rst_m1_hready", rr_M1_HREADY, 1'b1);
        chk("t6_rst_m0_hready", rr_M0_HREADY, 1'b1);
        chk("t6_rst_htrans", rr_S_HTRANS, HTRANS_IDLE);
        chk("t6_rst_haddr", rr_S_HADDR, 32'h0);
        chk("t6_rst_hwdata", rr_S_HWDATA, 32'h0);
        chk("t6_rst_hsize", rr_S_HSIZE, 3'b000);
        chk("t6_rst_hwrite", rr_S_HWRITE, 1'b0);
        chk("t6_rst_fp_haddr", fp_S_HADDR, 32'h0);
        step(); step();
        HRESETn = 1'b1; S_HREADY = 1'b1;
        M1_HADDR = 32'h3000_0030; M1_HWRITE = 1'b0; M1_HTRANS = HTRANS_NONSEQ;
        step();
        M1_HTRANS = HTRANS_IDLE;
        step(); #1;
        chk("t6_post_htrans", rr_S_HTRANS, HTRANS_NONSEQ);
        chk("t6_post_haddr", rr_S_HADDR, 32'h3000_0030);
        step(); #1;
        chk("t6_post_m1_hready", rr_M1_HREADY, 1'b1);
        chk("t6_post_m0_hready", rr_M0_HREADY, 1'b1);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
